seg7_decoder: RTL and testbench

SEG7_DECODER -- requirements
Module: seg7_decoder

---
 rtl/seg7_decoder.sv | 178 +++++++++++++++++
 tb/tb_seg7_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_decoder.sv
// Seven-segment frame decoder: captures six 8-bit segment patterns, decodes one
// digit per cycle into hex nibbles, decimal points and per-digit error flags,
// then presents the result under a valid/ready handshake.
// Optional build macro: SEG7_DP_CHECK_EN -- when defined, a lit decimal point
// also flags that digit as an error.
module seg7_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] seg_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] val_out,
    output logic [5:0]  dp_out,
    output logic [5:0]  err_mask,
    output logic        err_out,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [47:0] r_shadow;
    logic [2:0]  r_idx;
    logic [23:0] r_work_val;
    logic [5:0]  r_work_dp;
    logic [5:0]  r_work_err;
    logic [23:0] r_val;
    logic [5:0]  r_dp;
    logic [5:0]  r_err_mask;
    logic        r_err;

    logic [7:0]  w_pat;
    logic [7:0]  w_key;
    logic [3:0]  w_nib;
    logic        w_bad;
    logic        w_dp_err;
    logic [23:0] w_work_val_d;
    logic [5:0]  w_work_dp_d;
    logic [5:0]  w_work_err_d;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic: accept in IDLE, six scan cycles, hold DONE until handshake
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: if (in_valid) w_state_d = StScan;
            StScan: if (r_idx == 3'd5) w_state_d = StDone;
            StDone: if (out_ready) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Select the pattern of the digit currently being scanned
    always_comb begin
        w_pat = 8'h00;
        case (r_idx)
            3'd0: w_pat = r_shadow[7:0];
            3'd1: w_pat = r_shadow[15:8];
            3'd2: w_pat = r_shadow[23:16];
            3'd3: w_pat = r_shadow[31:24];
            3'd4: w_pat = r_shadow[39:32];
            3'd5: w_pat = r_shadow[47:40];
            default: w_pat = 8'h00;
        endcase
    end

    // Segment decode; dp is masked off so the key matches the table values
    always_comb begin
        w_key = {w_pat[7:1], 1'b0};
        w_nib = 4'h0;
        w_bad = 1'b0;
        case (w_key)
            8'hFC: w_nib = 4'h0;
            8'h60: w_nib = 4'h1;
            8'hDA: w_nib = 4'h2;
            8'hF2: w_nib = 4'h3;
            8'h66: w_nib = 4'h4;
            8'hB6: w_nib = 4'h5;
            8'hBE: w_nib = 4'h6;
            8'hE0: w_nib = 4'h7;
            8'hFE: w_nib = 4'h8;
            8'hF6: w_nib = 4'h9;
            8'hEE: w_nib = 4'hA;
            8'h3E: w_nib = 4'hB;
            8'h9C: w_nib = 4'hC;
            8'h7A: w_nib = 4'hD;
            8'h9E: w_nib = 4'hE;
            8'h8E: w_nib = 4'hF;
            default: w_bad = 1'b1;
        endcase
`ifdef SEG7_DP_CHECK_EN
        w_dp_err = w_pat[0];
`else
        w_dp_err = 1'b0;
`endif
    end

    // Merge the current digit into the working result
    always_comb begin
        w_work_val_d = r_work_val;
        w_work_dp_d  = r_work_dp;
        w_work_err_d = r_work_err;
        for (int i = 0; i < 6; i++) begin
            if (r_idx == 3'(i)) begin
                w_work_val_d[i*4 +: 4] = w_nib;
                w_work_dp_d[i]         = w_pat[0];
                w_work_err_d[i]        = w_bad | w_dp_err;
            end
        end
    end

    // Datapath: capture frame, accumulate digits, publish on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow   <= '0;
            r_idx      <= '0;
            r_work_val <= '0;
            r_work_dp  <= '0;
            r_work_err <= '0;
            r_val      <= '0;
            r_dp       <= '0;
            r_err_mask <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_shadow   <= seg_in;
                        r_idx      <= '0;
                        r_work_val <= '0;
                        r_work_dp  <= '0;
                        r_work_err <= '0;
                    end
                end
                StScan: begin
                    r_work_val <= w_work_val_d;
                    r_work_dp  <= w_work_dp_d;
                    r_work_err <= w_work_err_d;
                    r_idx      <= r_idx + 3'd1;
                    // Last digit goes straight to the outputs, so results
                    // are visible the cycle after the sixth scan edge
                    if (r_idx == 3'd5) begin
                        r_val      <= w_work_val_d;
                        r_dp       <= w_work_dp_d;
                        r_err_mask <= w_work_err_d;
                        r_err      <= |w_work_err_d;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags derive directly from the state
    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
        val_out   = r_val;
        dp_out    = r_dp;
        err_mask  = r_err_mask;
        err_out   = r_err;
    end

endmodule

// File: tb/tb_seg7_decoder.sv
// Directed testbench for seg7_decoder; expected values are hand-computed from
// the segment table. Build with SEG7_DP_CHECK_EN to match a dp-checking DUT.
module tb_seg7_decoder;

    logic        clk;
    logic        rst;
    logic [47:0] seg_in;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] val_out;
    logic [5:0]  dp_out;
    logic [5:0]  err_mask;
    logic        err_out;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SEG7_DP_CHECK_EN
    localparam logic [5:0] MaskDp3  = 6'b001000;
    localparam logic [5:0] MaskMix  = 6'b010001;
`else
    localparam logic [5:0] MaskDp3  = 6'b000000;
    localparam logic [5:0] MaskMix  = 6'b000001;
`endif

    seg7_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .val_out   (val_out),
        .dp_out    (dp_out),
        .err_mask  (err_mask),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a frame for one cycle; returns at the negedge after the accept edge
    task automatic start_frame(input logic [47:0] f);
        @(negedge clk);
        chk("in_ready_before_frame", 32'(in_ready), 32'd1);
        seg_in   = f;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        seg_in   = ~f;
    endtask

    // Bounded wait for out_valid; expects it exactly six edges after accept
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd6);
    endtask

    task automatic check_out(input string tag, input logic [23:0] v,
                             input logic [5:0] dp, input logic [5:0] m);
        chk({tag, "_val"}, 32'(val_out), 32'(v));
        chk({tag, "_dp"}, 32'(dp_out), 32'(dp));
        chk({tag, "_mask"}, 32'(err_mask), 32'(m));
        chk({tag, "_err"}, 32'(err_out), 32'(|m));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_ov_after_hs"}, 32'(out_valid), 32'd0);
        chk({tag, "_ir_after_hs"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [47:0] f, input logic [23:0] v,
                             input logic [5:0] dp, input logic [5:0] m);
        start_frame(f);
        chk({tag, "_ov_early"}, 32'(out_valid), 32'd0);
        wait_done(tag);
        check_out(tag, v, dp, m);
        release_out(tag);
    endtask

    initial begin
        int ov_cycles;
        rst       = 1'b1;
        seg_in    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_val", 32'(val_out), 32'd0);
        chk("rst_dp", 32'(dp_out), 32'd0);
        chk("rst_mask", 32'(err_mask), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);

        run_frame("f101010", 48'h60FC60FC60FC, 24'h101010, 6'b000000, 6'b000000);
        run_frame("fFEDCBA", 48'h8E9E7A9C3EEE, 24'hFEDCBA, 6'b000000, 6'b000000);
        run_frame("f987654", 48'hF6FEE0BEB666, 24'h987654, 6'b000000, 6'b000000);
        run_frame("f230100", 48'hDAF2FC60FCFC, 24'h230100, 6'b000000, 6'b000000);
        run_frame("fdp3", 48'hFCFC61FCFCFC, 24'h001000, 6'b001000, MaskDp3);
        // digit4=FF decodes as 8 with dp lit; digit0=00 is not in the table
        run_frame("fmix", 48'hFCFFFCFCFC00, 24'h080000, 6'b010000, MaskMix);

        // Results persist in IDLE after the handshake
        @(negedge clk);
        chk("idle_hold_val", 32'(val_out), 32'h080000);

        // Stall in DONE while inputs toggle
        start_frame(48'h60FC60FC60FC);
        wait_done("stall");
        for (int i = 0; i < 10; i++) begin
            seg_in   = {$urandom, $urandom_range(65535, 0)};
            in_valid = i[0];
            @(negedge clk);
            chk("stall_ov", 32'(out_valid), 32'd1);
            chk("stall_ir", 32'(in_ready), 32'd0);
            chk("stall_val", 32'(val_out), 32'h101010);
        end
        in_valid = 1'b0;
        release_out("stall");

        // out_ready held high beforehand gives a single cycle of out_valid
        out_ready = 1'b1;
        start_frame(48'h8E9E7A9C3EEE);
        ov_cycles = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) ov_cycles++;
        end
        chk("early_ready_ov_cycles", 32'(ov_cycles), 32'd1);
        chk("early_ready_val", 32'(val_out), 32'hFEDCBA);
        out_ready = 1'b0;

        // Reset mid-scan aborts the frame
        start_frame(48'hF6FEE0BEB666);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_val", 32'(val_out), 32'd0);
        chk("abort_dp", 32'(dp_out), 32'd0);
        chk("abort_mask", 32'(err_mask), 32'd0);
        chk("abort_err", 32'(err_out), 32'd0);
        ov_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) ov_cycles++;
        end
        chk("abort_no_result", 32'(ov_cycles), 32'd0);

        // Decoder still works after the abort
        run_frame("post_abort", 48'hFCFC61FCFCFC, 24'h001000, 6'b001000, MaskDp3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
